arbitro_rr_umbral: RTL and testbench
====================================

// Module: arbitro_rr_umbral
// PURPOSE
//  Round-robin scheduler for the transaction layer. Drains N_REQ show-ahead input FIFOs into one shared
//  output FIFO, one word per cycle. Applies hysteresis flow control from the threshold pair loaded on init:
//  stops popping at umbral_alto, resumes at umbral_bajo. Sits between the per-class input FIFOs and the
//  output FIFO, beside the threshold/idle FSM that supplies init and the thresholds.
// PARAMETERS
//  N_REQ   4  number of input FIFOs / requesters (2..8)
//  DATA_W  6  word width
//  CNT_W   3  threshold width; out_count is CNT_W+1 bits
// PORTS
//  clk           in   1              single clock, all logic on posedge
//  reset         in   1              synchronous, active-low
//  init          in   1              load thresholds (pulse or level)
//  umbral_alto   in   CNT_W          stall threshold, sampled in CFG
//  umbral_bajo   in   CNT_W          resume threshold, sampled in CFG
//  fifo_empty    in   N_REQ          input FIFO empty flags, bit i = FIFO i
//  fifo_data     in   N_REQ*DATA_W   show-ahead heads, FIFO i at [i*DATA_W +: DATA_W]
//  out_count     in   CNT_W+1        output FIFO occupancy
//  fifo_pop      out  N_REQ          one-hot pop, combinational, same cycle as grant
//  push_out      out  1              registered write strobe to output FIFO
//  data_out      out  DATA_W         registered word, valid with push_out
//  grant_idx     out  clog2(N_REQ)   registered index of the last granted FIFO
//  stall         out  1              registered, 1 in STALL
//  idle_arb      out  1              combinational, 1 in ARB when all fifo_empty and push_out=0
//  cfg_err       out  1              registered, 1 when latched umbral_bajo >= umbral_alto
// BEHAVIOUR
//  - Reset (reset=0 at posedge):
//    - state=RESET; push_out=0, data_out=0, stall=0, cfg_err=0, alto_q=bajo_q=0.
//    - rr pointer=N_REQ-1 so the first search starts at FIFO 0; grant_idx=N_REQ-1.
//    - fifo_pop=0 while in RESET.
//  - States:
//    - RESET -> WAIT_CFG unconditionally.
//    - WAIT_CFG: no pops; init -> CFG.
//    - CFG: latch alto_q/bajo_q; no pops.
//      - bajo_q>=alto_q (or alto_q=0): set cfg_err, go to WAIT_CFG.
//      - otherwise: clear cfg_err, go to ARB.
//    - ARB: grant per the rules below. Enter STALL when (out_count + push_out) >= alto_q, evaluated before
//      granting; no pop occurs in that cycle.
//    - STALL: no pops; return to ARB when out_count <= bajo_q.
//    - init in any state except RESET overrides the transition: next state = CFG.
//  - Grant (ARB, not stalling):
//    - Pick the first i with fifo_empty[i]=0, searching cyclically from ptr+1.
//    - fifo_pop[i]=1 in that cycle.
//    - Next cycle: push_out=1, data_out=word i, grant_idx=i, ptr=i.
//    - No candidate: fifo_pop=0, push_out=0 next cycle, ptr unchanged.
//  - Latency: one cycle pop->push; throughput one word per cycle.
//  - An in-flight push (pop on the last ARB cycle) always completes, even across a STALL/CFG entry.
//  - The rr pointer wraps N_REQ-1 -> 0.
//  - Width rule: threshold compares zero-extend to CNT_W+1 bits; out_count+push_out is computed in
//    CNT_W+2 bits (no overflow).
//  - data_out holds its last value when push_out=0.
// STRUCTURE
//  - Shared package/include arbitro_defs: state encodings RESET=0, WAIT_CFG=1, CFG=2, ARB=3, STALL=4
//    (3-bit), and the default widths.
//  - One natural sub-module: rr_prioridad (combinational round-robin search: fifo_empty, ptr -> one-hot
//    grant + valid).
//  - Everything else (state register, hysteresis, output registers) lives here.
// TESTING
//  - Reset, init with alto=6, bajo=2 -> WAIT_CFG, CFG, ARB; cfg_err=0; all outputs at reset values.
//  - All 4 FIFOs non-empty (2 words each), out_count=0 -> pops 0,1,2,3,0,1,2,3 on consecutive cycles;
//    push_out one cycle later each time, data_out matching.
//  - Only FIFO 2 non-empty, ptr=2 -> FIFO 2 granted again (wrap search returns to itself).
//  - out_count rises to 5 with push_out=1 -> STALL that cycle, no pop.
//    - out_count=3 -> still stalled; out_count=2 -> back to ARB, pops resume.
//  - init with alto=2, bajo=3 -> cfg_err=1, stays in WAIT_CFG, no pops.
//    - Re-init with 4/1 -> cfg_err=0, ARB.
//  - init asserted mid-stream after a pop -> that push still completes; CFG has no pop; new thresholds
//    take effect. reset=0 mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/arbitro_rr_umbral_pkg.sv
// Shared definitions for the round-robin threshold scheduler: FSM encoding and default widths.
package arbitro_rr_umbral_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int DATA_W_DEF = 6;
  localparam int CNT_W_DEF  = 3;

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_WAIT_CFG = 3'd1,
    ST_CFG      = 3'd2,
    ST_ARB      = 3'd3,
    ST_STALL    = 3'd4
  } estado_t;

endpackage

// File: rtl/rr_prioridad.sv
// Combinational round-robin search: first non-empty FIFO after ptr, cyclically.
module rr_prioridad #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] fifo_empty,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    // k runs to N_REQ so a lone requester at ptr wins against itself.
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      automatic logic [31:0]      c    = (32'(ptr) + k) % N_REQ;
      automatic logic [IDX_W-1:0] cidx = c[IDX_W-1:0];
      if (!valid && !fifo_empty[cidx]) begin
        valid       = 1'b1;
        grant[cidx] = 1'b1;
        idx         = cidx;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr_umbral.sv
// Round-robin drain of N_REQ show-ahead FIFOs into one output FIFO with hysteresis flow control.
module arbitro_rr_umbral
  import arbitro_rr_umbral_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [CNT_W-1:0]           umbral_alto,
  input  logic [CNT_W-1:0]           umbral_bajo,
  input  logic [N_REQ-1:0]           fifo_empty,
  input  logic [N_REQ*DATA_W-1:0]    fifo_data,
  input  logic [CNT_W:0]             out_count,
  output logic [N_REQ-1:0]           fifo_pop,
  output logic                       push_out,
  output logic [DATA_W-1:0]          data_out,
  output logic [$clog2(N_REQ)-1:0]   grant_idx,
  output logic                       stall,
  output logic                       idle_arb,
  output logic                       cfg_err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int OCC_W = CNT_W + 2;

  estado_t          estado, estado_sig;
  logic [CNT_W-1:0] alto_q, bajo_q;
  logic [IDX_W-1:0] ptr;
  logic [N_REQ-1:0] grant;
  logic             grant_ok;
  logic [IDX_W-1:0] grant_sel;
  logic [OCC_W-1:0] ocupacion;
  logic             lleno, reanudar, cfg_mala, pop_ok;

  rr_prioridad #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .fifo_empty (fifo_empty),
    .ptr        (ptr),
    .grant      (grant),
    .valid      (grant_ok),
    .idx        (grant_sel)
  );

  // The pending push counts toward occupancy so the stall decision sees the word already in flight.
  assign ocupacion = OCC_W'(out_count) + OCC_W'(push_out);
  assign lleno     = ocupacion >= OCC_W'(alto_q);
  assign reanudar  = out_count <= (CNT_W+1)'(bajo_q);
  assign cfg_mala  = umbral_bajo >= umbral_alto;
  assign pop_ok    = (estado == ST_ARB) && !lleno && grant_ok;

  always_ff @(posedge clk) begin
    if (!reset) estado <= ST_RESET;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      ST_RESET:    estado_sig = ST_WAIT_CFG;
      ST_WAIT_CFG: if (init) estado_sig = ST_CFG;
      ST_CFG:      estado_sig = cfg_mala ? ST_WAIT_CFG : ST_ARB;
      ST_ARB:      if (lleno) estado_sig = ST_STALL;
      ST_STALL:    if (reanudar) estado_sig = ST_ARB;
      default:     estado_sig = ST_RESET;
    endcase
    if (init && estado != ST_RESET) estado_sig = ST_CFG;
  end

  always_comb begin
    fifo_pop = pop_ok ? grant : '0;
    idle_arb = (estado == ST_ARB) && (&fifo_empty) && !push_out;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      push_out <= 1'b0;
      data_out <= '0;
      ptr      <= IDX_W'(N_REQ - 1);
      stall    <= 1'b0;
      cfg_err  <= 1'b0;
      alto_q   <= '0;
      bajo_q   <= '0;
    end else begin
      push_out <= pop_ok;
      if (pop_ok) begin
        data_out <= fifo_data[grant_sel*DATA_W +: DATA_W];
        ptr      <= grant_sel;
      end
      if (estado == ST_CFG) begin
        alto_q  <= umbral_alto;
        bajo_q  <= umbral_bajo;
        cfg_err <= cfg_mala;
      end
      stall <= (estado_sig == ST_STALL);
    end
  end

  assign grant_idx = ptr;

endmodule

// File: tb/tb_arbitro_rr_umbral.sv
// Randomized bench for arbitro_rr_umbral against a queue-based behavioural scheduler model.
module tb_arbitro_rr_umbral;

  localparam int N  = 4;
  localparam int DW = 6;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            reset, init;
  logic [CW-1:0]   umbral_alto, umbral_bajo;
  logic [N-1:0]    fifo_empty;
  logic [N*DW-1:0] fifo_data;
  logic [CW:0]     out_count;
  logic [N-1:0]    fifo_pop;
  logic            push_out;
  logic [DW-1:0]   data_out;
  logic [1:0]      grant_idx;
  logic            stall, idle_arb, cfg_err;

  arbitro_rr_umbral #(
    .N_REQ  (N),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .umbral_alto (umbral_alto),
    .umbral_bajo (umbral_bajo),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .out_count   (out_count),
    .fifo_pop    (fifo_pop),
    .push_out    (push_out),
    .data_out    (data_out),
    .grant_idx   (grant_idx),
    .stall       (stall),
    .idle_arb    (idle_arb),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: the input FIFOs are queues, the scheduler phase is a name.
  logic [DW-1:0] q [N][$];
  string         m_fase = "none";
  bit            m_ok = 0;
  bit            m_push, m_stall, m_err;
  logic [DW-1:0] m_dout;
  logic [CW-1:0] m_alto, m_bajo;
  int            m_ptr;
  logic [CW-1:0] ua, ub;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    vectors++;
    if (obs !== esp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  task automatic cargar(input int i, input int n);
    for (int k = 0; k < n; k++) q[i].push_back(DW'($urandom));
  endtask

  task automatic paso(input logic rn, input logic ini, input logic [CW:0] oc);
    int sel, occ, nl;
    logic [N-1:0] exp_pop;
    logic [DW-1:0] w;
    bit lleno, todo_vacio;
    string nf;
    @(negedge clk);
    reset = rn; init = ini; umbral_alto = ua; umbral_bajo = ub; out_count = oc;
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (q[i].size() == 0);
      fifo_data[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : DW'($urandom);
    end
    #1;
    occ = int'(oc) + int'(m_push);
    lleno = occ >= int'(m_alto);
    sel = -1;
    todo_vacio = 1;
    for (int i = 0; i < N; i++) if (q[i].size() != 0) todo_vacio = 0;
    if (m_fase == "arb" && !lleno)
      for (int k = 1; k <= N; k++) begin
        nl = (m_ptr + k) % N;
        if (sel < 0 && q[nl].size() != 0) sel = nl;
      end
    exp_pop = '0;
    if (sel >= 0) exp_pop[sel] = 1'b1;
    if (m_ok) begin
      comprobar("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
      comprobar("idle_arb", 32'(idle_arb), 32'(m_fase == "arb" && todo_vacio && !m_push));
    end
    @(posedge clk);
    w = '0;
    if (sel >= 0) w = q[sel].pop_front();
    if (!rn) begin
      m_ok = 1; m_fase = "reset"; m_push = 0; m_dout = '0; m_ptr = N - 1;
      m_stall = 0; m_err = 0; m_alto = '0; m_bajo = '0;
    end else begin
      m_push = (sel >= 0);
      if (sel >= 0) begin m_dout = w; m_ptr = sel; end
      nf = m_fase;
      if (m_fase == "reset") nf = "espera";
      else if (m_fase == "espera") begin if (ini) nf = "cfg"; end
      else if (m_fase == "cfg") begin
        m_alto = ua; m_bajo = ub; m_err = (ub >= ua);
        nf = m_err ? "espera" : "arb";
      end
      else if (m_fase == "arb") begin if (lleno) nf = "stall"; end
      else if (m_fase == "stall") begin if (oc <= {1'b0, m_bajo}) nf = "arb"; end
      if (ini && m_fase != "reset") nf = "cfg";
      m_fase = nf;
      m_stall = (nf == "stall");
    end
    #1;
    if (m_ok) begin
      comprobar("push_out",  32'(push_out),  32'(m_push));
      comprobar("data_out",  32'(data_out),  32'(m_dout));
      comprobar("grant_idx", 32'(grant_idx), 32'(m_ptr));
      comprobar("stall",     32'(stall),     32'(m_stall));
      comprobar("cfg_err",   32'(cfg_err),   32'(m_err));
    end
  endtask

  task automatic arrancar(input logic [CW-1:0] a, input logic [CW-1:0] b);
    ua = a; ub = b;
    paso(1'b1, 1'b1, '0);
    paso(1'b1, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ua = '0; ub = '0;
    reset = 1'b0; init = 1'b0; out_count = '0;
    fifo_empty = '1; fifo_data = '0;
    umbral_alto = '0; umbral_bajo = '0;

    // Reset, then configure 6/2 and idle in ARB.
    paso(1'b0, 1'b0, '0);
    paso(1'b0, 1'b0, '0);
    paso(1'b1, 1'b0, '0);
    arrancar(3'd6, 3'd2);
    repeat (2) paso(1'b1, 1'b0, '0);

    // Full rotation: two words in every FIFO.
    for (int i = 0; i < N; i++) cargar(i, 2);
    repeat (10) paso(1'b1, 1'b0, '0);

    // Only FIFO 2: search wraps back to the last grantee.
    cargar(2, 3);
    repeat (5) paso(1'b1, 1'b0, '0);

    // Hysteresis: 5 + pending push reaches alto=6, resume at bajo=2.
    for (int i = 0; i < N; i++) cargar(i, 3);
    paso(1'b1, 1'b0, 4'd0);
    paso(1'b1, 1'b0, 4'd5);
    paso(1'b1, 1'b0, 4'd3);
    paso(1'b1, 1'b0, 4'd3);
    paso(1'b1, 1'b0, 4'd2);
    repeat (4) paso(1'b1, 1'b0, 4'd0);

    // Bad thresholds, then a good re-init.
    cargar(1, 2);
    arrancar(3'd2, 3'd3);
    repeat (3) paso(1'b1, 1'b0, '0);
    arrancar(3'd4, 3'd1);
    repeat (2) paso(1'b1, 1'b0, '0);

    // init mid-stream and reset mid-stream.
    for (int i = 0; i < N; i++) cargar(i, 2);
    paso(1'b1, 1'b0, '0);
    arrancar(3'd5, 3'd2);
    repeat (2) paso(1'b1, 1'b0, '0);
    paso(1'b0, 1'b0, '0);
    paso(1'b1, 1'b0, '0);
    arrancar(3'd6, 3'd2);

    // Random traffic, occupancy, re-configuration and occasional reset.
    for (int c = 0; c < 600; c++) begin
      logic          rn, ini;
      logic [CW:0]   oc;
      if ($urandom_range(0, 3) == 0) cargar($urandom_range(0, N - 1), $urandom_range(1, 2));
      oc = ($urandom_range(0, 9) == 0) ? 4'(15) : 4'($urandom_range(0, 7));
      ini = ($urandom_range(0, 29) == 0);
      if (ini) begin
        ua = CW'($urandom_range(0, 7));
        ub = CW'($urandom_range(0, 7));
      end
      rn = ($urandom_range(0, 149) != 0);
      paso(rn, ini, oc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
